mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester and the data-memory requester of the CPU datapath.
- The data requester is driven by the control unit's dREN/dWEN.
- A registered FSM grants one requester at a time and holds the grant until RAM completes, errors or times out.
- Drives wait/load back to each requester. Default priority is data over instruction, so load/store never stalls behind fetch.

Parameters:
WORD_W, 32, address/data width
TIMEOUT_CYC, 64, max cycles in a serve state without ACCESS before abort (>=2)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
iREN  input  1  instruction read request
iaddr  input  WORD_W  instruction address
iwait  output  1  instruction not complete
iload  output  WORD_W  instruction read data
dREN  input  1  data read request
dWEN  input  1  data write request
daddr  input  WORD_W  data address
dstore  input  WORD_W  data write value
dwait  output  1  data not complete
dload  output  WORD_W  data read data
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  WORD_W  RAM address
ramstore  output  WORD_W  RAM write data
ramload  input  WORD_W  RAM read data
ramstate  input  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
ram_err  output  1  one-cycle pulse: RAM ERROR during a grant
tmo  output  1  one-cycle pulse: grant aborted by timeout

Behaviour:
- Clock and reset: single clock CLK; synchronous active-high reset RST.
- States: IDLE, DSERV, ISERV. Registers: state, 16-bit-min cycle counter cnt, last_d flag (round-robin only), ram_err, tmo.
- Reset (RST high at an edge): state=IDLE, cnt=0, last_d=0, ram_err=0, tmo=0.
  - Reset mid-serve aborts without completion.
  - While in IDLE, ramREN=ramWEN=0, ramaddr=ramstore=0.
- IDLE arbitration:
  - If (dREN|dWEN), next state DSERV.
  - Else if iREN, next state ISERV.
  - Else stay in IDLE.
  - The RAM is never driven in IDLE.
- DSERV RAM outputs (combinational from current inputs):
  - ramWEN=dWEN.
  - ramREN=dREN&~dWEN (write wins if both asserted).
  - ramaddr=daddr, ramstore=dstore.
- ISERV RAM outputs: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
- Wait outputs:
  - dwait = (dREN|dWEN) & ~(state==DSERV & ramstate==ACCESS).
  - iwait = iREN & ~(state==ISERV & ramstate==ACCESS).
  - An ERROR completion also drops wait for the granted requester in that cycle.
- Load outputs:
  - dload=ramload when in DSERV, else 0.
  - iload=ramload when in ISERV, else 0.
- Latency: request first seen in IDLE at cycle N → RAM enabled at N+1. If ramstate==ACCESS at N+1, wait falls at N+1. Minimum 2 cycles, wait high in cycle N.
- Serve exit, next state IDLE on the edge after any of:
  - ramstate==ACCESS: completion.
  - ramstate==ERROR: ram_err=1 for the next cycle.
  - Granted requester drops its request: abort, no pulse.
  - cnt==TIMEOUT_CYC-1 without ACCESS: tmo=1 for the next cycle; requester keeps waiting and is re-arbitrated.
- Counter: cnt increments each serve cycle and clears on entry to IDLE.
- Back-to-back: the earliest re-grant is the cycle after IDLE, so there is always one IDLE cycle between grants.
- Requesters must hold address/data stable while wait is high; the arbiter does not latch them.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined:
  - last_d is set on leaving DSERV and cleared on leaving ISERV.
  - In IDLE with both requesting, the grant goes to instruction if last_d=1, else to data.
  - This guarantees fetch progress under continuous data traffic.
- ARB_ROUND_ROBIN_EN undefined: fixed data priority; last_d is absent.

Test Plan:
- Reset then iREN=1, iaddr=0x100, RAM returns ACCESS on first enabled cycle with ramload=0x2408000A:
  - ramREN=1 and ramaddr=0x100 at N+1.
  - iwait=0 and iload=0x2408000A at N+1.
  - Back to IDLE at N+2.
- iREN=1 and dWEN=1 in the same cycle, daddr=0x80, dstore=0xDEADBEEF:
  - DSERV first: ramWEN=1, ramstore=0xDEADBEEF.
  - After ACCESS, one IDLE cycle, then ISERV.
  - iwait stays 1 throughout.
- dREN=dWEN=1 → ramWEN=1, ramREN=0.
- ramstate held BUSY in ISERV with TIMEOUT_CYC=4:
  - tmo pulses exactly once, 4 cycles after grant.
  - Arbiter returns to IDLE, then re-grants ISERV since iREN is still high.
- ramstate=ERROR during DSERV:
  - dwait=0 that cycle, ram_err=1 next cycle, state IDLE.
- With ARB_ROUND_ROBIN_EN, dREN and iREN held continuously, RAM always ACCESS:
  - Grants alternate D, I, D, I.
  - Without the macro: D only, iwait never falls.
- Assert RST during DSERV with BUSY:
  - Next cycle ramREN=ramWEN=0, state IDLE, no pulses.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the CPU requesters, the shared RAM port and the mem_arbiter.
// The slave modport is the arbiter's view; master is the surrounding datapath/RAM view.
interface mem_arbiter_if #(
   parameter int WORD_W = 32
);
   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;
   logic              dREN;
   logic              dWEN;
   logic [WORD_W-1:0] daddr;
   logic [WORD_W-1:0] dstore;
   logic              dwait;
   logic [WORD_W-1:0] dload;
   logic              ramREN;
   logic              ramWEN;
   logic [WORD_W-1:0] ramaddr;
   logic [WORD_W-1:0] ramstore;
   logic [WORD_W-1:0] ramload;
   logic [1:0]        ramstate;
   logic              ram_err;
   logic              tmo;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err, tmo
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
      input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err, tmo
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access; data wins by default.
// Define ARB_ROUND_ROBIN_EN to alternate grants when both requesters are pending.
module mem_arbiter #(
   parameter int WORD_W      = 32,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic          CLK,
   input  logic          RST,
   mem_arbiter_if.slave  bus
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYC) > 16) ? $clog2(TIMEOUT_CYC) : 16;
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DSERV = 2'd1,
      ISERV = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic             ram_err_q;
   logic             tmo_q;
   logic             d_req;
   logic             gnt_req;
   logic             access;
   logic             error;
   logic             timeout;
   logic             serve_end;
`ifdef ARB_ROUND_ROBIN_EN
   logic             last_d;
`endif

   assign d_req   = bus.dREN | bus.dWEN;
   assign access  = (bus.ramstate == RAM_ACCESS);
   assign error   = (bus.ramstate == RAM_ERROR);
   assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));
   assign gnt_req = (state == DSERV) ? d_req :
                    (state == ISERV) ? bus.iREN : 1'b0;
   // Any of these ends a grant; precedence only matters for which pulse fires.
   assign serve_end = access | error | ~gnt_req | timeout;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         ram_err_q <= 1'b0;
         tmo_q     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_d    <= 1'b0;
`endif
      end else begin
         state     <= state_nx;
         cnt       <= (state == IDLE || state_nx == IDLE) ? '0 : cnt + CNT_W'(1);
         ram_err_q <= (state != IDLE) & error;
         tmo_q     <= (state != IDLE) & timeout & ~access & ~error & gnt_req;
`ifdef ARB_ROUND_ROBIN_EN
         if (state == DSERV && state_nx == IDLE)
            last_d <= 1'b1;
         else if (state == ISERV && state_nx == IDLE)
            last_d <= 1'b0;
`endif
      end
   end

   // NOTE: default assignment first so no path through the block leaves state_nx unassigned (no latch).
   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
            if (d_req && bus.iREN && last_d)
               state_nx = ISERV;
            else
`endif
            if (d_req)
               state_nx = DSERV;
            else if (bus.iREN)
               state_nx = ISERV;
         end
         DSERV, ISERV: begin
            if (serve_end)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.dload    = '0;
      bus.iload    = '0;
      case (state)
         DSERV: begin
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN & ~bus.dWEN;
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            bus.dload    = bus.ramload;
         end
         ISERV: begin
            bus.ramREN   = 1'b1;
            bus.ramaddr  = bus.iaddr;
            bus.iload    = bus.ramload;
         end
         default: ;
      endcase
      // An ERROR completion releases the granted requester just like ACCESS.
      bus.dwait = d_req    & ~((state == DSERV) & (access | error));
      bus.iwait = bus.iREN & ~((state == ISERV) & (access | error));
   end

   assign bus.ram_err = ram_err_q;
   assign bus.tmo     = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario-driven bench for mem_arbiter; read data is checked through an expected-load queue.
// Round-robin expectations follow ARB_ROUND_ROBIN_EN as compiled.
module tb_mem_arbiter;

   localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

   typedef struct {
      bit          is_d;
      logic [31:0] data;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];
   exp_t e;

   mem_arbiter_if #(.WORD_W(32)) bus ();

   mem_arbiter #(.WORD_W(32), .TIMEOUT_CYC(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   // {ramREN, ramWEN, iwait, dwait, ram_err, tmo}
   function automatic logic [5:0] flags();
      return {bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ram_err, bus.tmo};
   endfunction

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      @(negedge CLK);
   endtask

   task automatic idle_inputs();
      bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
      bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramstate = FREE;
   endtask

   task automatic apply_reset();
      idle_inputs();
      RST = 1;
      next_cycle();
      next_cycle();
      RST = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      settle();
      vectors++;
      if (flags() !== 6'b000000) begin
         miscompares++; $display("FAIL reset_flags got=%b exp=%b", flags(), 6'b000000);
      end
      vectors++;
      if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== 128'd0) begin
         miscompares++; $display("FAIL reset_bus got=%h exp=0", {bus.ramaddr, bus.ramstore});
      end
      next_cycle();
   endtask

   task automatic test_ifetch();
      apply_reset();
      bus.iREN = 1; bus.iaddr = 32'h100;
      settle();
      vectors++;
      if (flags() !== 6'b001000) begin
         miscompares++; $display("FAIL ifetch_req got=%b exp=%b", flags(), 6'b001000);
      end
      sb.push_back('{is_d: 0, data: 32'h2408000A});
      next_cycle();
      bus.ramstate = ACCESS; bus.ramload = 32'h2408000A;
      settle();
      vectors++;
      if ({flags(), bus.ramaddr} !== {6'b100000, 32'h100}) begin
         miscompares++; $display("FAIL ifetch_grant got=%b/%h exp=100000/00000100", flags(), bus.ramaddr);
      end
      e = sb.pop_front();
      vectors++;
      if (bus.iload !== e.data) begin
         miscompares++; $display("FAIL ifetch_load got=%h exp=%h", bus.iload, e.data);
      end
      next_cycle();
      bus.iREN = 0; bus.ramstate = FREE;
      settle();
      vectors++;
      if ({flags(), bus.iload} !== {6'b000000, 32'h0}) begin
         miscompares++; $display("FAIL ifetch_idle got=%b/%h exp=000000/0", flags(), bus.iload);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      apply_reset();
      bus.iREN = 1; bus.iaddr = 32'h200;
      bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'hDEADBEEF;
      settle();
      vectors++;
      if (flags() !== 6'b001100) begin
         miscompares++; $display("FAIL b2b_req got=%b exp=%b", flags(), 6'b001100);
      end
      next_cycle();
      bus.ramstate = BUSY;
      settle();
      vectors++;
      if ({flags(), bus.ramaddr, bus.ramstore} !== {6'b011100, 32'h80, 32'hDEADBEEF}) begin
         miscompares++;
         $display("FAIL b2b_dserv got=%b/%h/%h exp=011100/00000080/deadbeef", flags(), bus.ramaddr, bus.ramstore);
      end
      next_cycle();
      bus.ramstate = ACCESS;
      settle();
      vectors++;
      if (flags() !== 6'b011000) begin
         miscompares++; $display("FAIL b2b_dacc got=%b exp=%b", flags(), 6'b011000);
      end
      next_cycle();
      bus.dWEN = 0; bus.ramstate = FREE;
      settle();
      vectors++;
      if (flags() !== 6'b001000) begin
         miscompares++; $display("FAIL b2b_gap got=%b exp=%b", flags(), 6'b001000);
      end
      sb.push_back('{is_d: 0, data: 32'h11112222});
      next_cycle();
      bus.ramstate = ACCESS; bus.ramload = 32'h11112222;
      settle();
      e = sb.pop_front();
      vectors++;
      if ({flags(), bus.ramaddr, bus.iload} !== {6'b100000, 32'h200, e.data}) begin
         miscompares++;
         $display("FAIL b2b_iserv got=%b/%h/%h exp=100000/00000200/%h", flags(), bus.ramaddr, bus.iload, e.data);
      end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_read_write();
      apply_reset();
      bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h44; bus.dstore = 32'h5;
      next_cycle();
      bus.ramstate = ACCESS;
      settle();
      vectors++;
      if (flags() !== 6'b010000) begin
         miscompares++; $display("FAIL rw_both got=%b exp=%b", flags(), 6'b010000);
      end
      next_cycle();
      idle_inputs();
      bus.dREN = 1; bus.daddr = 32'h48;
      sb.push_back('{is_d: 1, data: 32'hCAFEF00D});
      next_cycle();
      bus.ramstate = ACCESS; bus.ramload = 32'hCAFEF00D;
      settle();
      e = sb.pop_front();
      vectors++;
      if ({flags(), bus.ramaddr, bus.dload, bus.iload} !== {6'b100000, 32'h48, e.data, 32'h0}) begin
         miscompares++;
         $display("FAIL rw_read got=%b/%h/%h/%h exp=100000/00000048/%h/0", flags(), bus.ramaddr, bus.dload, bus.iload, e.data);
      end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_timeout();
      int tmo_seen = 0;
      apply_reset();
      bus.iREN = 1; bus.iaddr = 32'h300; bus.ramstate = BUSY;
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         settle();
         tmo_seen += int'(bus.tmo);
         vectors++;
         if (flags() !== 6'b101000) begin
            miscompares++; $display("FAIL tmo_busy%0d got=%b exp=%b", k, flags(), 6'b101000);
         end
         next_cycle();
      end
      settle();
      tmo_seen += int'(bus.tmo);
      vectors++;
      if (flags() !== 6'b001001) begin
         miscompares++; $display("FAIL tmo_pulse got=%b exp=%b", flags(), 6'b001001);
      end
      next_cycle();
      bus.ramstate = ACCESS; bus.ramload = 32'h33;
      sb.push_back('{is_d: 0, data: 32'h33});
      settle();
      tmo_seen += int'(bus.tmo);
      e = sb.pop_front();
      vectors++;
      if ({flags(), bus.iload} !== {6'b100000, e.data}) begin
         miscompares++; $display("FAIL tmo_regrant got=%b/%h exp=100000/%h", flags(), bus.iload, e.data);
      end
      vectors++;
      if (tmo_seen !== 1) begin
         miscompares++; $display("FAIL tmo_count got=%0d exp=1", tmo_seen);
      end
      next_cycle();
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_error();
      apply_reset();
      bus.dREN = 1; bus.daddr = 32'h90;
      next_cycle();
      bus.ramstate = ERROR;
      settle();
      vectors++;
      if (flags() !== 6'b100000) begin
         miscompares++; $display("FAIL err_cycle got=%b exp=%b", flags(), 6'b100000);
      end
      next_cycle();
      bus.dREN = 0; bus.ramstate = FREE;
      settle();
      vectors++;
      if (flags() !== 6'b000010) begin
         miscompares++; $display("FAIL err_pulse got=%b exp=%b", flags(), 6'b000010);
      end
      next_cycle();
      settle();
      vectors++;
      if (flags() !== 6'b000000) begin
         miscompares++; $display("FAIL err_clear got=%b exp=%b", flags(), 6'b000000);
      end
      next_cycle();
   endtask

   task automatic test_arbitration();
      bit rr = 0;
      bit last_d_m = 0;
      bit gnt_i;
`ifdef ARB_ROUND_ROBIN_EN
      rr = 1;
`endif
      apply_reset();
      bus.dREN = 1; bus.daddr = 32'h10; bus.iREN = 1; bus.iaddr = 32'h20; bus.ramstate = ACCESS;
      for (int k = 0; k < 4; k++) begin
         gnt_i    = rr && last_d_m;
         last_d_m = !gnt_i;
         sb.push_back('{is_d: !gnt_i, data: 32'h700 + k});
         next_cycle();
         bus.ramload = 32'h700 + k;
         settle();
         e = sb.pop_front();
         vectors++;
         if ({bus.ramaddr, bus.iwait, bus.dwait} !== {(gnt_i ? 32'h20 : 32'h10), !gnt_i, gnt_i}) begin
            miscompares++;
            $display("FAIL arb_grant%0d got=%h/%b%b exp=%h/%b%b", k, bus.ramaddr, bus.iwait, bus.dwait,
                     (gnt_i ? 32'h20 : 32'h10), !gnt_i, gnt_i);
         end
         vectors++;
         if ((e.is_d ? bus.dload : bus.iload) !== e.data) begin
            miscompares++; $display("FAIL arb_load%0d got=%h exp=%h", k, (e.is_d ? bus.dload : bus.iload), e.data);
         end
         next_cycle();
         settle();
         vectors++;
         if (flags() !== 6'b001100) begin
            miscompares++; $display("FAIL arb_gap%0d got=%b exp=%b", k, flags(), 6'b001100);
         end
      end
      idle_inputs();
      next_cycle();
   endtask

   task automatic test_reset_mid_serve();
      apply_reset();
      bus.dWEN = 1; bus.daddr = 32'hA0; bus.ramstate = BUSY;
      next_cycle();
      settle();
      vectors++;
      if (flags() !== 6'b010100) begin
         miscompares++; $display("FAIL rst_serve got=%b exp=%b", flags(), 6'b010100);
      end
      RST = 1;
      next_cycle();
      RST = 0;
      settle();
      vectors++;
      if (flags() !== 6'b000100) begin
         miscompares++; $display("FAIL rst_abort got=%b exp=%b", flags(), 6'b000100);
      end
      bus.dWEN = 0;
      next_cycle();
      settle();
      vectors++;
      if (flags() !== 6'b000000) begin
         miscompares++; $display("FAIL rst_quiet got=%b exp=%b", flags(), 6'b000000);
      end
      next_cycle();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_ifetch();
      test_back_to_back();
      test_read_write();
      test_timeout();
      test_error();
      test_arbitration();
      test_reset_mid_serve();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
